thunderbolt_seq_ctrl: RTL and testbench

// Sequencing controller that sits directly upstream of the thunderbolt datapath.
// It drives the four one-hot draw enables and enable_animate.
// It consumes the per-sprite done flags, done_animate and done_tb.

---
 rtl/thunderbolt_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_thunderbolt_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/thunderbolt_seq_ctrl.sv
// Thunderbolt attack sequencer: Pikachu pose, repeated L/M/S bolt draws with
// frame-delay holds between them, then a finish pulse (or abort on a stuck draw).
module thunderbolt_seq_ctrl #(
  parameter int DRAW_TIMEOUT = 20000,
  parameter int MAX_ROUNDS   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic done_tb_pika,
  input  logic done_L_tb,
  input  logic done_M_tb,
  input  logic done_S_tb,
  input  logic done_animate,
  input  logic done_tb,
  output logic enable_draw_tb_pika,
  output logic enable_draw_L_tb,
  output logic enable_draw_M_tb,
  output logic enable_draw_S_tb,
  output logic enable_animate,
  output logic plot,
  output logic busy,
  output logic finished,
  output logic timeout_err
);
  localparam int TW = $clog2(DRAW_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_ROUNDS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DRAW_TIMEOUT - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(MAX_ROUNDS - 1);
  localparam logic [RW-1:0] ROUND_MAX  = RW'(MAX_ROUNDS);

  typedef enum logic [3:0] {
    IDLE, PIKA, HOLD_P, DRAW_L, HOLD_L, DRAW_M, HOLD_M, DRAW_S, HOLD_S, FINISH, ABORT
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [RW-1:0] round_reg, round_next;
  logic          in_draw;
  logic          timer_expired;

  assign timer_expired = (timer_reg == TIMER_LAST);

  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    in_draw    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        round_next = '0;
        if (start) state_next = PIKA;
      end
      PIKA: begin
        in_draw = 1'b1;
        if (done_tb_pika)       state_next = HOLD_P;
        else if (timer_expired) state_next = ABORT;
      end
      DRAW_L: begin
        in_draw = 1'b1;
        if (done_L_tb)          state_next = HOLD_L;
        else if (timer_expired) state_next = ABORT;
      end
      DRAW_M: begin
        in_draw = 1'b1;
        if (done_M_tb)          state_next = HOLD_M;
        else if (timer_expired) state_next = ABORT;
      end
      DRAW_S: begin
        in_draw = 1'b1;
        if (done_S_tb)          state_next = HOLD_S;
        else if (timer_expired) state_next = ABORT;
      end
      HOLD_P: begin
        if (done_tb)           state_next = FINISH;
        else if (done_animate) state_next = DRAW_L;
      end
      HOLD_L: begin
        if (done_tb)           state_next = FINISH;
        else if (done_animate) state_next = DRAW_M;
      end
      HOLD_M: begin
        if (done_tb)           state_next = FINISH;
        else if (done_animate) state_next = DRAW_S;
      end
      HOLD_S: begin
        if (done_tb) begin
          state_next = FINISH;
        end else if (done_animate) begin
          // The round just completed is counted before deciding whether to loop.
          state_next = (round_reg >= ROUND_LAST) ? FINISH : DRAW_L;
          if (round_reg != ROUND_MAX) round_next = round_reg + 1'b1;
        end
      end
      FINISH:  state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every draw state is entered from a different state, so the timer starts at 0.
  assign timer_next = (in_draw && state_next == state_reg) ? timer_reg + 1'b1 : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg           <= IDLE;
      timer_reg           <= '0;
      round_reg           <= '0;
      enable_draw_tb_pika <= 1'b0;
      enable_draw_L_tb    <= 1'b0;
      enable_draw_M_tb    <= 1'b0;
      enable_draw_S_tb    <= 1'b0;
      enable_animate      <= 1'b0;
      busy                <= 1'b0;
      finished            <= 1'b0;
      timeout_err         <= 1'b0;
    end else begin
      state_reg           <= state_next;
      timer_reg           <= timer_next;
      round_reg           <= round_next;
      enable_draw_tb_pika <= (state_next == PIKA);
      enable_draw_L_tb    <= (state_next == DRAW_L);
      enable_draw_M_tb    <= (state_next == DRAW_M);
      enable_draw_S_tb    <= (state_next == DRAW_S);
      enable_animate      <= (state_next == HOLD_P) || (state_next == HOLD_L) ||
                             (state_next == HOLD_M) || (state_next == HOLD_S);
      busy                <= (state_next != IDLE);
      finished            <= (state_next == FINISH);
      if (state_next == ABORT)
        timeout_err <= 1'b1;
      else if (state_reg == IDLE && start)
        timeout_err <= 1'b0;
    end
  end

  assign plot = enable_draw_tb_pika | enable_draw_L_tb | enable_draw_M_tb | enable_draw_S_tb;

endmodule

// File: tb/tb_thunderbolt_seq_ctrl.sv
// Scoreboard bench for thunderbolt_seq_ctrl: a reactive responder plays the draw
// modules and frame timer, a monitor checks enable/finish/abort events in order.
module tb_thunderbolt_seq_ctrl;
  localparam int EV_PIKA = 0, EV_L = 1, EV_M = 2, EV_S = 3, EV_FIN = 4, EV_ABORT = 5;

  logic clock = 1'b0;
  logic reset, start;
  logic done_tb_pika, done_L_tb, done_M_tb, done_S_tb, done_animate, done_tb;
  logic enable_draw_tb_pika, enable_draw_L_tb, enable_draw_M_tb, enable_draw_S_tb;
  logic enable_animate, plot, busy, finished, timeout_err;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  // Responder configuration, written only by the main stimulus process.
  bit block_l = 1'b0;
  int tb_hold = 0;
  bit both_mode = 1'b0;

  always #5 clock = ~clock;

  thunderbolt_seq_ctrl #(.DRAW_TIMEOUT(16), .MAX_ROUNDS(2)) dut (
    .clock(clock), .reset(reset), .start(start),
    .done_tb_pika(done_tb_pika), .done_L_tb(done_L_tb), .done_M_tb(done_M_tb),
    .done_S_tb(done_S_tb), .done_animate(done_animate), .done_tb(done_tb),
    .enable_draw_tb_pika(enable_draw_tb_pika), .enable_draw_L_tb(enable_draw_L_tb),
    .enable_draw_M_tb(enable_draw_M_tb), .enable_draw_S_tb(enable_draw_S_tb),
    .enable_animate(enable_animate), .plot(plot), .busy(busy),
    .finished(finished), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int all_outs();
    return {enable_draw_tb_pika, enable_draw_L_tb, enable_draw_M_tb, enable_draw_S_tb,
            enable_animate, plot, busy, finished, timeout_err};
  endfunction

  // Draw modules answer 4 cycles after enable; frame timer answers 10 cycles into a hold.
  initial begin
    int en_cyc = 0, an_cyc = 0, hold_idx = 0;
    forever begin
      @(negedge clock);
      done_tb_pika = 1'b0; done_L_tb = 1'b0; done_M_tb = 1'b0; done_S_tb = 1'b0;
      done_animate = 1'b0; done_tb = 1'b0;
      if (!busy) hold_idx = 0;
      if (plot) begin
        en_cyc++;
        if (en_cyc == 4) begin
          if (enable_draw_tb_pika)          done_tb_pika = 1'b1;
          if (enable_draw_L_tb && !block_l) done_L_tb = 1'b1;
          if (enable_draw_M_tb)             done_M_tb = 1'b1;
          if (enable_draw_S_tb)             done_S_tb = 1'b1;
        end
      end else en_cyc = 0;
      if (enable_animate) begin
        if (an_cyc == 0) hold_idx++;
        an_cyc++;
        if (an_cyc == 10) begin
          if (hold_idx == tb_hold) begin
            done_tb = 1'b1;
            if (both_mode) done_animate = 1'b1;
          end else done_animate = 1'b1;
        end
      end else an_cyc = 0;
    end
  end

  task automatic pop_expect(input int code);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event_unexpected actual=%0d required=none", code);
    end else begin
      e = exp_q.pop_front();
      if (e != code) begin
        failures++;
        $display("FAIL event_order actual=%0d required=%0d", code, e);
      end else $display("event %0d ok at %0t", code, $time);
    end
  endtask

  // Monitor: one-hot/plot invariants every cycle, events popped from the scoreboard.
  initial begin
    logic pp = 0, pl = 0, pm = 0, ps = 0, pf = 0, pt = 0;
    forever begin
      @(negedge clock);
      check("onehot", $countones({enable_draw_tb_pika, enable_draw_L_tb,
                                  enable_draw_M_tb, enable_draw_S_tb}) <= 1, 1);
      check("plot_or", plot, enable_draw_tb_pika | enable_draw_L_tb |
                             enable_draw_M_tb | enable_draw_S_tb);
      if (pf) begin
        check("finish_one_cycle", finished, 0);
        check("busy_after_finish", busy, 0);
      end
      if (enable_draw_tb_pika && !pp) pop_expect(EV_PIKA);
      if (enable_draw_L_tb && !pl)    pop_expect(EV_L);
      if (enable_draw_M_tb && !pm)    pop_expect(EV_M);
      if (enable_draw_S_tb && !ps)    pop_expect(EV_S);
      if (finished && !pf)            pop_expect(EV_FIN);
      if (timeout_err && !pt)         pop_expect(EV_ABORT);
      pp = enable_draw_tb_pika; pl = enable_draw_L_tb; pm = enable_draw_M_tb;
      ps = enable_draw_S_tb; pf = finished; pt = timeout_err;
    end
  end

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin @(negedge clock); n++; end
    check({name, "_idle_reached"}, busy, 0);
    repeat (2) @(negedge clock);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b1;
    repeat (3) @(negedge clock);
    check("outs_in_reset", all_outs(), 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("outs_after_reset", all_outs(), 0);

    // Normal run, done_tb on the 5th hold.
    tb_hold = 5;
    exp_q.push_back(EV_PIKA); exp_q.push_back(EV_L); exp_q.push_back(EV_M);
    exp_q.push_back(EV_S); exp_q.push_back(EV_L); exp_q.push_back(EV_FIN);
    pulse_start();
    wait_idle("normal");
    check("normal_no_timeout", timeout_err, 0);

    // Stuck large-bolt draw.
    tb_hold = 0; block_l = 1'b1;
    exp_q.push_back(EV_PIKA); exp_q.push_back(EV_L); exp_q.push_back(EV_ABORT);
    pulse_start();
    n = 0;
    while (!enable_draw_L_tb && n < 100) begin @(negedge clock); n++; end
    check("timeout_l_entered", enable_draw_L_tb, 1);
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clock); n++; end
    check("timeout_latency", n, 16);
    wait_idle("timeout");
    repeat (5) @(negedge clock);
    check("timeout_sticky", timeout_err, 1);
    check("timeout_no_finish", finished, 0);
    block_l = 1'b0;

    // Round backstop (MAX_ROUNDS=2), done_tb never asserted; start clears the error.
    exp_q.push_back(EV_PIKA);
    exp_q.push_back(EV_L); exp_q.push_back(EV_M); exp_q.push_back(EV_S);
    exp_q.push_back(EV_L); exp_q.push_back(EV_M); exp_q.push_back(EV_S);
    exp_q.push_back(EV_FIN);
    pulse_start();
    check("start_clears_timeout", timeout_err, 0);
    wait_idle("rounds");

    // done_tb and done_animate together in HOLD_M.
    tb_hold = 3; both_mode = 1'b1;
    exp_q.push_back(EV_PIKA); exp_q.push_back(EV_L); exp_q.push_back(EV_M);
    exp_q.push_back(EV_FIN);
    pulse_start();
    wait_idle("priority");
    both_mode = 1'b0; tb_hold = 0;

    // Reset in DRAW_M.
    exp_q.push_back(EV_PIKA); exp_q.push_back(EV_L); exp_q.push_back(EV_M);
    pulse_start();
    n = 0;
    while (!enable_draw_M_tb && n < 200) begin @(negedge clock); n++; end
    check("reset_m_entered", enable_draw_M_tb, 1);
    reset = 1'b1;
    @(negedge clock);
    check("reset_m_enable_low", enable_draw_M_tb, 0);
    check("reset_m_outs", all_outs(), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_m_idle", all_outs(), 0);
    check("reset_m_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
